// File: rtl/key_repeater.sv
// key_repeater
//   Turns a debounced key level into single-cycle events: a press pulse on
//   the rising edge, a release pulse on the falling edge of an accepted
//   press, and typematic auto-repeat pulses while the key stays down.
//
// Ports
//   async_reset    in   asynchronous reset, active low
//   clk            in   system clock
//   signal_input   in   debounced key level, 1 = pressed
//   enable         in   1 = generate events, 0 = hold FSM idle, no pulses
//   held           out  registered key level
//   press_pulse    out  one-cycle pulse per accepted press
//   release_pulse  out  one-cycle pulse when an accepted press is released
//   repeat_pulse   out  one-cycle pulse per auto-repeat
//   event_pulse    out  press_pulse | repeat_pulse
//   repeat_count   out  repeats since last press, saturating at 255
//
// State table
//   state     | meaning
//   ST_IDLE   | key not accepted; waiting for a fresh rising edge
//   ST_DELAY  | press issued; timing initial delay to first repeat
//   ST_REPEAT | repeating; timing period between repeat pulses

module key_repeater #(
  parameter int INITIAL_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_WIDTH     = 25
) (
  input  logic       async_reset,
  input  logic       clk,
  input  logic       signal_input,
  input  logic       enable,
  output logic       held,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic       event_pulse,
  output logic [7:0] repeat_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(INITIAL_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

  state_t               state_q,   state_d;
  logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic                 in_q,      in_d;
  logic                 prev_q,    prev_d;
  logic                 press_q,   press_d;
  logic                 release_q, release_d;
  logic                 repeat_q,  repeat_d;
  logic                 event_q,   event_d;
  logic [7:0]           rcount_q,  rcount_d;

  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt_last;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      in_q      <= 1'b0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      event_q   <= 1'b0;
      rcount_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_q      <= in_d;
      prev_q    <= prev_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      event_q   <= event_d;
      rcount_q  <= rcount_d;
    end
  end

  always_comb begin
    in_d      = signal_input;
    prev_d    = in_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    event_d   = 1'b0;
    rcount_d  = rcount_q;
    rise      = in_q & ~prev_q;
    cnt_last  = (state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST;

    if (!enable) begin
      // Disabled: drop back to idle silently. A key still held when enable
      // returns produces no rise, so it must be released and pressed again.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (rise) begin
            press_d  = 1'b1;
            event_d  = 1'b1;
            rcount_d = 8'd0;
            state_d  = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          // Release wins over a repeat that would fire on the same cycle.
          if (!in_q) begin
            release_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else if (cnt_q == cnt_last) begin
            repeat_d = 1'b1;
            event_d  = 1'b1;
            cnt_d    = '0;
            state_d  = ST_REPEAT;
            if (rcount_q != 8'hFF) begin
              rcount_d = rcount_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign held          = in_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign event_pulse   = event_q;
  assign repeat_count  = rcount_q;

endmodule

// File: doc/key_repeater.md
# key_repeater

Converts a clean, debounced key level into single-cycle key events: one press pulse on the rising edge, a release pulse on the falling edge, and auto-repeat pulses while the key stays held. It sits directly after the debouncer on each DE0 push-button or switch path. It feeds counters, menus and register controls that need one action per press plus typematic repeat.

## Interface
Parameters:
- INITIAL_DELAY, 25000000, clock cycles from the press pulse to the first repeat pulse (500 ms at 50 MHz); legal range 2..2^CNT_WIDTH-1.
- REPEAT_PERIOD, 5000000, clock cycles between consecutive repeat pulses (100 ms at 50 MHz); legal range 2..2^CNT_WIDTH-1.
- CNT_WIDTH, 25, width of the internal delay counter.

Ports:
- async_reset  input  1  reset, asynchronous, active-low.
- clk  input  1  system clock, 50 MHz on DE0. This is the single clock.
- signal_input  input  1  debounced key level, 1 = pressed.
- enable  input  1  1 = event generation on; 0 = FSM held in IDLE with no pulses.
- held  output  1  registered copy of the key level (in_reg).
- press_pulse  output  1  one-cycle pulse on each accepted press.
- release_pulse  output  1  one-cycle pulse on release of an accepted press.
- repeat_pulse  output  1  one-cycle pulse for each auto-repeat.
- event_pulse  output  1  press_pulse OR repeat_pulse, registered.
- repeat_count  output  8  repeats since the last press, saturating at 255.

## Operation
- Input stage: in_reg <= signal_input and prev_reg <= in_reg on every clk. The rise flag is in_reg & ~prev_reg; the fall flag is ~in_reg & prev_reg.
- FSM states are IDLE, DELAY and REPEAT, with a CNT_WIDTH-bit counter.
- All pulse outputs default to 0 on every cycle and are set only as listed below.
- IDLE:
  - counter = 0.
  - If enable and rise: press_pulse <= 1, event_pulse <= 1, repeat_count <= 0, counter <= 0, go to DELAY.
- DELAY:
  - If ~in_reg: release_pulse <= 1, go to IDLE.
  - Else if counter == INITIAL_DELAY-1: repeat_pulse <= 1, event_pulse <= 1, counter <= 0, repeat_count += 1, go to REPEAT.
  - Else counter += 1.
- REPEAT:
  - Same as DELAY, using REPEAT_PERIOD-1 as the compare value; the state stays REPEAT.
  - repeat_count saturates at 255; repeat pulses continue after saturation.
- Release has priority over a repeat fire in the same cycle. No repeat pulse is issued on the release cycle.
- A rise is only possible from IDLE. A press needs a fresh 0->1 transition of in_reg.
- enable = 0:
  - Next state is IDLE and counter <= 0; no pulses of any kind, including release.
  - held still tracks in_reg.
  - If enable returns while the key is still held, no press pulse is issued until the key is released and pressed again.
- The counter never wraps, because it is cleared on every fire and on every entry to IDLE.

## Timing
- Reset values: all outputs 0, in_reg = prev_reg = 0, state IDLE, counter 0.
- Reset mid-operation (async_reset low at any time) immediately forces these values. If the key is held across reset release, in_reg goes 0->1 and a press is accepted, producing press_pulse 2 edges after reset deassertion.
- Input latency:
  - signal_input rising before edge E gives held = 1 after E.
  - press_pulse is high for exactly the cycle after edge E+1.
  - release latency is the same: 2 edges.
- Press pulse registered at edge P:
  - first repeat_pulse is registered at edge P+INITIAL_DELAY;
  - each following repeat_pulse is registered REPEAT_PERIOD edges after the previous one.
- Every pulse output is exactly 1 cycle wide. press_pulse and repeat_pulse are never asserted together.

## Test plan
Use INITIAL_DELAY = 10, REPEAT_PERIOD = 4 and a 20 ns clock for scenarios 1-5; scenario 6 uses default parameters.
1. Reset, then signal_input = 1 for 5 cycles, then 0 -> one press_pulse and one event_pulse at edge 2, one release_pulse 2 edges after the drop; repeat_pulse and repeat_count stay 0.
2. Hold for 30 cycles after the press at edge P -> repeat_pulse at P+10, P+14, P+18, P+22, P+26, P+30; repeat_count = 6; release_pulse 2 edges after the drop.
3. Release timed so in_reg falls exactly on the cycle the counter equals 9 in DELAY -> release_pulse only, no repeat_pulse, FSM returns to IDLE.
4. Hold with repeat_count already saturated at 255 (shorter fire counts are acceptable via a forced counter) -> repeat_count stays 255 and repeat_pulse keeps firing every 4 cycles.
5. Press, drop enable at P+5 for 20 cycles while held, then raise enable -> no pulses at all. Then release and press again -> press_pulse resumes.
6. Assert async_reset low in REPEAT while held, release it with the key held -> all outputs 0 immediately; press_pulse 2 edges after deassertion; first repeat_pulse INITIAL_DELAY edges after that press_pulse (default parameters: 25000000).
